// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Field positions and opcode values are also used by the control unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  localparam int PC_STEP = 4;

  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] FUNC_SYSCALL = 6'h0C;

  function automatic logic is_syscall(input logic [31:0] word);
    return (word[OPCODE_MSB:OPCODE_LSB] == OP_RTYPE) &&
           (word[FUNC_MSB:FUNC_LSB] == FUNC_SYSCALL);
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Pair of saturating event counters for the fetch unit: accepted
// instructions and stall cycles. Used only under FETCH_PERF_COUNTERS_EN.
module fetch_perf_counters import fetch_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_inc,
  input  logic         stall_inc,
  output logic [W-1:0] fetch_count,
  output logic [W-1:0] stall_count
);

  logic [W-1:0] fetch_q, fetch_d;
  logic [W-1:0] stall_q, stall_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    if (fetch_inc && (fetch_q != '1)) fetch_d = fetch_q + W'(1);
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign fetch_count = fetch_q;
  assign stall_count = stall_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-issue MIPS fetch front end: PC, req/ack instruction fetch, issue to decode.
// Optional performance counters are built when FETCH_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit import fetch_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc_plus4,
  input  logic              halted,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              cpu_halted,
  output logic [31:0]       perf_fetch_count,
  output logic [31:0]       perf_stall_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              cpu_halted_q, cpu_halted_d;

  // imem_req is registered so it stays low for one cycle after reset; an ack
  // is only honoured while the request is actually on the bus.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    cpu_halted_d = cpu_halted_q;
    case (state_q)
      ST_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          if (halted) begin
            cpu_halted_d = 1'b1;
            imem_req_d   = 1'b0;
            state_d      = ST_HALT;
          end else begin
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
            if (redirect_valid) pc_d = redirect_pc & ~ADDR_W'(3);
            else                pc_d = pc_q + ADDR_W'(PC_STEP);
          end
        end
      end
      ST_HALT: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      cpu_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      cpu_halted_q <= cpu_halted_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = inst_valid_q;
  assign opcode        = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign func          = inst_q[FUNC_MSB:FUNC_LSB];
  assign inst_pc       = pc_q;
  assign inst_pc_plus4 = pc_q + ADDR_W'(PC_STEP);
  assign cpu_halted    = cpu_halted_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = (state_q == ST_ISSUE) && inst_ready;
  assign stall_inc = ((state_q == ST_FETCH) && imem_req_q && !imem_ack) ||
                     ((state_q == ST_ISSUE) && !inst_ready);

  fetch_perf_counters #(.W(32)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_inc   (fetch_inc),
    .stall_inc   (stall_inc),
    .fetch_count (perf_fetch_count),
    .stall_count (perf_stall_count)
  );
`else
  assign perf_fetch_count = '0;
  assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, corner-case
// sequences and randomized transactions against a transaction-level PC model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        halted;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        cpu_halted;
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_stall_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pf;
  logic [31:0] exp_ps;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .opcode           (opcode),
    .func             (func),
    .inst_pc          (inst_pc),
    .inst_pc_plus4    (inst_pc_plus4),
    .halted           (halted),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .cpu_halted       (cpu_halted),
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count)
  );

  typedef struct {
    int          ack_wait;
    int          ready_wait;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F21;
  endfunction

  task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_COUNTERS_EN
    chk({tag, "_perf_fetch"}, perf_fetch_count, exp_pf);
    chk({tag, "_perf_stall"}, perf_stall_count, exp_ps);
`else
    chk({tag, "_perf_fetch"}, perf_fetch_count, 32'h0);
    chk({tag, "_perf_stall"}, perf_stall_count, 32'h0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    halted = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_halted", cpu_halted, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    exp_pf = '0;
    exp_ps = '0;
    chk_perf("rst");
    reset = 1'b0;
    step();
    chk("rst_req_rise", imem_req, 1'b1);
    chk("rst_req_addr", imem_addr, 32'h0);
    $display("txn reset: fetch restarts at %h", imem_addr);
  endtask

  // One fetch/issue transaction, entered on a cycle where imem_req is high.
  task automatic do_txn(input int ack_wait, input int ready_wait, input logic redir,
                        input logic [31:0] rpc, input logic halt,
                        input logic [31:0] exp_addr, input logic [31:0] word);
    chk("req_up", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, exp_addr);
    for (int w = 0; w < ack_wait; w++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      step();
      chk("req_hold", imem_req, 1'b1);
      chk("req_hold_addr", imem_addr, exp_addr);
      chk("wait_no_valid", inst_valid, 1'b0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", inst_valid, 1'b1);
    chk("inst", inst, word);
    chk("opcode", opcode, word[31:26]);
    chk("func", func, word[5:0]);
    chk("inst_pc", inst_pc, exp_addr);
    chk("inst_pc_plus4", inst_pc_plus4, exp_addr + 32'd4);
    chk("issue_req_low", imem_req, 1'b0);
    for (int r = 0; r < ready_wait; r++) begin
      inst_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = $urandom;
      halted = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      step();
      chk("bp_valid", inst_valid, 1'b1);
      chk("bp_inst", inst, word);
      chk("bp_req_low", imem_req, 1'b0);
      chk("bp_pc", inst_pc, exp_addr);
    end
    imem_ack = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = redir;
    redirect_pc = rpc;
    halted = halt;
    step();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    halted = 1'b0;
    chk("accept_valid_low", inst_valid, 1'b0);
    chk("accept_halted", cpu_halted, halt);
    chk("accept_req", imem_req, !halt);
    exp_pf = exp_pf + 1;
    exp_ps = exp_ps + ack_wait + ready_wait;
    chk_perf("txn");
    $display("txn addr=%h word=%h ack_wait=%0d ready_wait=%0d redir=%0d rpc=%h halt=%0d",
             exp_addr, word, ack_wait, ready_wait, redir, rpc, halt);
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] model_pc;
    logic [31:0] frozen_pf;
    logic [31:0] frozen_ps;

    vecs[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0000};
    vecs[1] = '{0, 0, 1'b0, 32'h0,         32'h0000_0004};
    vecs[2] = '{0, 0, 1'b0, 32'h0,         32'h0000_0008};
    vecs[3] = '{3, 0, 1'b0, 32'h0,         32'h0000_000C};
    vecs[4] = '{0, 5, 1'b1, 32'h0000_0103, 32'h0000_0010};
    vecs[5] = '{1, 2, 1'b1, 32'hFFFF_FFFE, 32'h0000_0100};
    vecs[6] = '{0, 0, 1'b0, 32'h0,         32'hFFFF_FFFC};
    vecs[7] = '{2, 1, 1'b0, 32'h0,         32'h0000_0000};
    vecs[8] = '{0, 0, 1'b0, 32'h0,         32'h0000_0004};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].ack_wait, vecs[i].ready_wait, vecs[i].redir, vecs[i].rpc,
             1'b0, vecs[i].exp_addr, mem_word(vecs[i].exp_addr));
    end

    // SYSCALL with a simultaneous redirect: halt wins and is sticky.
    do_txn(0, 1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0008, 32'h0000_000C);
    frozen_pf = exp_pf;
    frozen_ps = exp_ps;
    for (int c = 0; c < 8; c++) begin
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      inst_ready = $urandom_range(0, 1);
      halted = $urandom_range(0, 1);
      redirect_valid = $urandom_range(0, 1);
      redirect_pc = $urandom;
      step();
      chk("halt_req_low", imem_req, 1'b0);
      chk("halt_sticky", cpu_halted, 1'b1);
      chk("halt_valid_low", inst_valid, 1'b0);
    end
    exp_pf = frozen_pf;
    exp_ps = frozen_ps;
    chk_perf("halt_frozen");
    $display("txn halt: held for 8 cycles with random inputs");

    do_reset();
    do_txn(0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, mem_word(32'h0));

    // Reset lands on the same edge as an ack: the word must be discarded.
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b1;
    step();
    chk("midrst_req_low", imem_req, 1'b0);
    chk("midrst_valid_low", inst_valid, 1'b0);
    chk("midrst_inst", inst, 32'h0);
    imem_ack = 1'b0;
    reset = 1'b0;
    step();
    chk("midrst_req_rise", imem_req, 1'b1);
    chk("midrst_addr", imem_addr, 32'h0);
    exp_pf = '0;
    exp_ps = '0;
    chk_perf("midrst");
    $display("txn mid-fetch reset: fetch restarts at %h", imem_addr);

    model_pc = 32'h0;
    for (int n = 0; n < 150; n++) begin
      int          aw;
      int          rw;
      logic        rd;
      logic [31:0] tgt;
      aw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      rd = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      do_txn(aw, rw, rd, tgt, 1'b0, model_pc, mem_word(model_pc));
      model_pc = rd ? (tgt & 32'hFFFF_FFFC) : (model_pc + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
